// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the configurable UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } par_mode_e;

   // Wide enough to count a two-stop-bit period without wrapping.
   function automatic int tick_w(input int sb_tick);
      return $clog2(2 * sb_tick);
   endfunction

endpackage

// File: rtl/uart_tx_cfg_baud_gen.sv
// Oversample tick generator: one s_tick every dvsr+1 cycles, clear restarts the phase.
module uart_baud_gen #(
   parameter int DVSR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic              clear,
   output logic              s_tick
);

   logic [DVSR_W-1:0] cnt_q, cnt_d;

   assign s_tick = (cnt_q == dvsr);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || s_tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with latched per-frame config and back-to-back frames.
// Parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR_W  = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DBIT-1:0]   din,
   input  logic              tx_start,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic [1:0]        par_mode,
   input  logic              stop2,
   output logic              tx,
   output logic              tx_ready,
   output logic              tx_busy,
   output logic              tx_done_tick
);

   localparam int TW = tick_w(SB_TICK);
   localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [TW-1:0] BIT_LAST = TW'(SB_TICK - 1);
   localparam logic [TW-1:0] STOP2_LAST = TW'(2 * SB_TICK - 1);
   localparam logic [BW-1:0] N_LAST = BW'(DBIT - 1);

   tx_state_e         state_q, state_d;
   logic [TW-1:0]     s_q, s_d;
   logic [BW-1:0]     n_q, n_d;
   logic [DBIT-1:0]   b_q, b_d;
   logic [DVSR_W-1:0] dvsr_q, dvsr_d;
   logic              stop2_q, stop2_d;
   logic              tx_q, tx_d;
   logic              s_tick, accept, done;
   logic [TW-1:0]     stop_last;
   logic              pen_q, pbit_q;

`ifdef UART_TX_PARITY_EN
   logic pen_d, pbit_d;
`else
   logic unused_par;
   assign unused_par = ^par_mode;
   assign pen_q  = 1'b0;
   assign pbit_q = 1'b0;
`endif

   uart_baud_gen #(.DVSR_W(DVSR_W)) u_baud (
      .clk    (clk),
      .rst    (rst),
      .dvsr   (dvsr_q),
      .clear  (accept),
      .s_tick (s_tick)
   );

   assign stop_last    = stop2_q ? STOP2_LAST : BIT_LAST;
   assign done         = !rst && (state_q == STOP) && s_tick
                         && (s_q == stop_last);
   assign tx_done_tick = done;
   assign tx_ready     = (state_q == IDLE) || done;
   assign tx_busy      = (state_q != IDLE);
   assign accept       = tx_start && tx_ready;
   assign tx           = tx_q;

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      dvsr_d  = dvsr_q;
      stop2_d = stop2_q;
      tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
      pen_d   = pen_q;
      pbit_d  = pbit_q;
`endif
      if (accept) begin
         state_d = START;
         s_d     = '0;
         n_d     = '0;
         b_d     = din;
         dvsr_d  = dvsr;
         stop2_d = stop2;
         tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
         pen_d   = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
         pbit_d  = (^din) ^ (par_mode == PAR_ODD);
`endif
      end else if (s_tick) begin
         unique case (state_q)
            START: begin
               s_d = s_q + 1'b1;
               if (s_q == BIT_LAST) begin
                  state_d = DATA;
                  s_d     = '0;
                  tx_d    = b_q[0];
               end
            end
            DATA: begin
               s_d = s_q + 1'b1;
               if (s_q == BIT_LAST) begin
                  s_d = '0;
                  b_d = b_q >> 1;
                  if (n_q == N_LAST) begin
                     state_d = pen_q ? PARITY : STOP;
                     tx_d    = pen_q ? pbit_q : 1'b1;
                  end else begin
                     n_d  = n_q + 1'b1;
                     tx_d = b_q[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               s_d = s_q + 1'b1;
               if (s_q == BIT_LAST) begin
                  state_d = STOP;
                  s_d     = '0;
                  tx_d    = 1'b1;
               end
            end
`endif
            STOP: begin
               s_d = s_q + 1'b1;
               if (s_q == stop_last) begin
                  state_d = IDLE;
                  s_d     = '0;
                  tx_d    = 1'b1;
               end
            end
            default: begin
               tx_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         dvsr_q  <= '0;
         stop2_q <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         dvsr_q  <= dvsr_d;
         stop2_q <= stop2_d;
         tx_q    <= tx_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pen_q  <= 1'b0;
         pbit_q <= 1'b0;
      end else begin
         pen_q  <= pen_d;
         pbit_q <= pbit_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: frame waveforms vs. a bit-list model.
module tb_uart_tx_cfg;

   localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  din = '0;
   logic        tx_start = 1'b0;
   logic [10:0] dvsr = '0;
   logic [1:0]  par_mode = '0;
   logic        stop2 = 1'b0;
   logic        tx, tx_ready, tx_busy, tx_done_tick;

   int checks = 0;
   int failures = 0;

   uart_tx_cfg #(.DBIT(8), .SB_TICK(SB), .DVSR_W(11)) dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .tx_start     (tx_start),
      .dvsr         (dvsr),
      .par_mode     (par_mode),
      .stop2        (stop2),
      .tx           (tx),
      .tx_ready     (tx_ready),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic scramble();
      din      = 8'($urandom);
      dvsr     = 11'($urandom_range(0, 7));
      par_mode = 2'($urandom);
      stop2    = 1'($urandom);
   endtask

   // Requests a frame; returns at the start of the first start-bit cycle.
   task automatic start_frame(input string nm, input logic [7:0] d,
                              input int dv, input logic [1:0] pm,
                              input bit s2);
      @(posedge clk); #1;
      din = d; dvsr = 11'(dv); par_mode = pm; stop2 = s2;
      tx_start = 1'b1;
      @(negedge clk);
      checks++;
      if (tx_ready !== 1'b1 || tx !== 1'b1) begin
         failures++;
         $display("FAIL %s_accept: ready=%b tx=%b want 1 1", nm, tx_ready, tx);
      end
      @(posedge clk); #1;
      tx_start = 1'b0;
   endtask

   // Checks a whole frame cycle by cycle against the expected bit list.
   task automatic frame_body(input string nm, input logic [7:0] d,
                             input int dv, input logic [1:0] pm,
                             input bit s2, input bit disturb,
                             input bit chain, input logic [7:0] nd);
      bit exp[$];
      int per, len, bad, first, dhit, dbad, bbad;
      bit pen;
      pen = PEN && (pm == 2'b01 || pm == 2'b10);
      per = SB * (dv + 1);
      exp = {};
      repeat (per) exp.push_back(1'b0);
      for (int k = 0; k < 8; k++) repeat (per) exp.push_back(d[k]);
      if (pen) repeat (per) exp.push_back((^d) ^ (pm == 2'b10));
      repeat (per * (s2 ? 2 : 1)) exp.push_back(1'b1);
      len = exp.size();
      bad = 0; first = -1; dhit = 0; dbad = 0; bbad = 0;
      for (int i = 1; i <= len; i++) begin
         if (chain && i == len) begin
            tx_start = 1'b1; din = nd;
            dvsr = 11'(dv); par_mode = pm; stop2 = s2;
         end else if (disturb && i < len) begin
            scramble();
            tx_start = 1'($urandom);
         end else if (i == 1) begin
            scramble();
            tx_start = 1'b0;
         end else begin
            tx_start = 1'b0;
         end
         @(negedge clk);
         if (tx !== exp[i-1]) begin
            bad++;
            if (first < 0) first = i;
         end
         if (tx_done_tick === 1'b1) begin
            dhit++;
            if (i != len) dbad++;
         end
         if (tx_busy !== 1'b1 || tx_ready !== logic'(i == len)) bbad++;
         if (i < len) begin
            @(posedge clk); #1;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s_wave: %0d bad cycles (first at %0d of %0d) want 0",
                  nm, bad, first, len);
      end
      checks++;
      if (dhit != 1 || dbad != 0) begin
         failures++;
         $display("FAIL %s_done: pulses=%0d misplaced=%0d want 1 0",
                  nm, dhit, dbad);
      end
      checks++;
      if (bbad != 0) begin
         failures++;
         $display("FAIL %s_busy_ready: %0d bad cycles want 0", nm, bbad);
      end
   endtask

   task automatic idle_check(input string nm);
      @(posedge clk); #1;
      tx_start = 1'b0;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0) begin
         failures++;
         $display("FAIL %s_idle: tx=%b busy=%b done=%b want 1 0 0",
                  nm, tx, tx_busy, tx_done_tick);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1
          || tx_done_tick !== 1'b0) begin
         failures++;
         $display("FAIL reset: tx=%b busy=%b ready=%b done=%b want 1 0 1 0",
                  tx, tx_busy, tx_ready, tx_done_tick);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic_8n1();
      start_frame("basic", 8'h55, 0, 2'b00, 1'b0);
      frame_body("basic", 8'h55, 0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
      idle_check("basic");
   endtask

   task automatic test_parity_even();
      start_frame("even", 8'h01, 3, 2'b01, 1'b0);
      frame_body("even", 8'h01, 3, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
      idle_check("even");
   endtask

   task automatic test_parity_odd_stop2();
      start_frame("odd2", 8'h00, 1, 2'b10, 1'b1);
      frame_body("odd2", 8'h00, 1, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00);
      idle_check("odd2");
   endtask

   task automatic test_back_to_back();
      start_frame("b2b", 8'hA5, 0, 2'b01, 1'b0);
      frame_body("b2b_a", 8'hA5, 0, 2'b01, 1'b0, 1'b0, 1'b1, 8'h3C);
      @(posedge clk); #1;
      frame_body("b2b_b", 8'h3C, 0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
      idle_check("b2b");
   endtask

   task automatic test_mid_reset();
      int dh, lo;
      start_frame("rstmid", 8'hC3, 0, 2'b00, 1'b0);
      repeat (69) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_abort: tx=%b busy=%b ready=%b want 1 0 1",
                  tx, tx_busy, tx_ready);
      end
      rst = 1'b0;
      dh = 0; lo = 0;
      repeat (40) begin
         @(negedge clk);
         if (tx_done_tick === 1'b1) dh++;
         if (tx !== 1'b1) lo++;
      end
      checks++;
      if (dh != 0 || lo != 0) begin
         failures++;
         $display("FAIL rstmid_quiet: done=%0d low=%0d want 0 0", dh, lo);
      end
      start_frame("rstpost", 8'h96, 1, 2'b00, 1'b1);
      frame_body("rstpost", 8'h96, 1, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00);
      idle_check("rstpost");
   endtask

   task automatic test_busy_ignore();
      start_frame("busy", 8'h6B, 0, 2'b10, 1'b0);
      frame_body("busy", 8'h6B, 0, 2'b10, 1'b0, 1'b1, 1'b0, 8'h00);
      idle_check("busy");
   endtask

   task automatic test_random();
      logic [7:0] d;
      int dv;
      logic [1:0] pm;
      bit s2;
      for (int r = 0; r < 6; r++) begin
         d  = 8'($urandom);
         dv = $urandom_range(0, 2);
         pm = 2'($urandom);
         s2 = 1'($urandom);
         start_frame("rand", d, dv, pm, s2);
         frame_body("rand", d, dv, pm, s2, 1'b0, 1'b0, 8'h00);
         idle_check("rand");
      end
   endtask

   initial begin
      test_reset();
      test_basic_8n1();
      test_parity_even();
      test_parity_odd_stop2();
      test_back_to_back();
      test_mid_reset();
      test_busy_ignore();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
